// File: rtl/hilo_muldiv_seq_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// Covers funct codes, FSM state encoding and iteration counter sizing.
package hilo_muldiv_seq_pkg;

  localparam int FUNCT_W = 6;

  localparam logic [FUNCT_W-1:0] FN_MFHI  = 6'b010000;
  localparam logic [FUNCT_W-1:0] FN_MTHI  = 6'b010001;
  localparam logic [FUNCT_W-1:0] FN_MFLO  = 6'b010010;
  localparam logic [FUNCT_W-1:0] FN_MTLO  = 6'b010011;
  localparam logic [FUNCT_W-1:0] FN_MULT  = 6'b011000;
  localparam logic [FUNCT_W-1:0] FN_MULTU = 6'b011001;
  localparam logic [FUNCT_W-1:0] FN_DIV   = 6'b011010;
  localparam logic [FUNCT_W-1:0] FN_DIVU  = 6'b011011;

  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] LAST_ITER = 6'd31;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    FIX  = ST_FIX
  } state_t;

  function automatic logic is_muldiv(input logic [FUNCT_W-1:0] f);
    return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [FUNCT_W-1:0] f);
    return (f == FN_MULT) || (f == FN_DIV);
  endfunction

endpackage

// File: rtl/hilo_muldiv_seq_if.sv
// Pipeline-facing bus of the HI/LO unit: the issue side drives the op,
// the unit returns read data, stall/busy/done and the live HI/LO values.
interface hilo_muldiv_seq_if;
  import hilo_muldiv_seq_pkg::*;

  logic               op_valid;
  logic [FUNCT_W-1:0] funct;
  logic [31:0]        A;
  logic [31:0]        B;
  logic [31:0]        rd_data;
  logic               stall;
  logic               busy;
  logic               done;
  logic [31:0]        hi;
  logic [31:0]        lo;

  modport master (
    output op_valid, funct, A, B,
    input  rd_data, stall, busy, done, hi, lo
  );

  modport slave (
    input  op_valid, funct, A, B,
    output rd_data, stall, busy, done, hi, lo
  );

endinterface

// File: rtl/hilo_muldiv_seq_iter.sv
// One radix-2 step per cycle on unsigned magnitudes: shift-add multiply
// or restoring divide, both held in a single 64-bit accumulator.
module muldiv_iter
  import hilo_muldiv_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic        is_div,
  input  logic [31:0] a_mag,
  input  logic [31:0] b_mag,
  output logic [63:0] acc
);

  logic [63:0] acc_reg, acc_next;
  logic [31:0] opnd_reg;
  logic        div_mode_reg;

  logic [32:0] mul_sum;
  logic [32:0] div_top;
  logic [31:0] div_diff;
  logic        div_ge;

  // Multiply: low half starts as the multiplier and drains out as the product fills in.
  assign mul_sum = {1'b0, acc_reg[63:32]} + {1'b0, (acc_reg[0] ? opnd_reg : 32'd0)};

  // Divide: partial remainder shifted left with the next dividend bit; 33 bits wide
  // because the remainder can reach divisor-1 before the shift.
  assign div_top  = acc_reg[63:31];
  assign div_ge   = (div_top >= {1'b0, opnd_reg});
  assign div_diff = div_top[31:0] - opnd_reg;

  always_comb begin
    acc_next = acc_reg;
    if (load) begin
      acc_next = {32'd0, (is_div ? a_mag : b_mag)};
    end else if (step) begin
      if (div_mode_reg) begin
        acc_next = div_ge ? {div_diff, acc_reg[30:0], 1'b1}
                          : {div_top[31:0], acc_reg[30:0], 1'b0};
      end else begin
        acc_next = {mul_sum, acc_reg[31:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg      <= 64'd0;
      opnd_reg     <= 32'd0;
      div_mode_reg <= 1'b0;
    end else begin
      acc_reg <= acc_next;
      if (load) begin
        opnd_reg     <= is_div ? b_mag : a_mag;
        div_mode_reg <= is_div;
      end
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/hilo_muldiv_seq.sv
// HI/LO register file with a 32-iteration sequential multiply/divide engine.
// Moves to/from HI/LO are single-cycle; mult/div take 33 cycles then pulse done.
module hilo_muldiv_seq
  import hilo_muldiv_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  hilo_muldiv_seq_if.slave   bus
);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [31:0]       hi_reg, hi_next;
  logic [31:0]       lo_reg, lo_next;
  logic              done_reg, done_next;

  logic [31:0]       a_reg;
  logic              is_div_reg;
  logic              neg_reg;
  logic              rem_neg_reg;
  logic              b_zero_reg;

  logic              idle;
  logic              issue;
  logic              load;
  logic              step;
  logic              signed_op;
  logic              op_is_div;
  logic [31:0]       a_mag, b_mag;
  logic [63:0]       acc;
  logic [63:0]       prod;
  logic [31:0]       quot, rem;
  logic [31:0]       res_hi, res_lo;

  assign idle      = (state_reg == IDLE);
  assign issue     = bus.op_valid && idle;
  assign signed_op = is_signed_op(bus.funct);
  // funct bit 1 separates div/divu from mult/multu within the muldiv group.
  assign op_is_div = bus.funct[1];
  assign a_mag     = (signed_op && bus.A[31]) ? (32'd0 - bus.A) : bus.A;
  assign b_mag     = (signed_op && bus.B[31]) ? (32'd0 - bus.B) : bus.B;

  muldiv_iter u_iter (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .is_div (op_is_div),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .acc    (acc)
  );

  assign prod = neg_reg     ? (64'd0 - acc)        : acc;
  assign quot = neg_reg     ? (32'd0 - acc[31:0])  : acc[31:0];
  assign rem  = rem_neg_reg ? (32'd0 - acc[63:32]) : acc[63:32];

  always_comb begin
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if (b_zero_reg) begin
      res_hi = a_reg;
      res_lo = 32'hFFFF_FFFF;
    end else if (is_div_reg) begin
      res_hi = rem;
      res_lo = quot;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    done_next  = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (issue) begin
          if (is_muldiv(bus.funct)) begin
            load       = 1'b1;
            count_next = '0;
            state_next = CALC;
          end else if (bus.funct == FN_MTHI) begin
            hi_next = bus.A;
          end else if (bus.funct == FN_MTLO) begin
            lo_next = bus.A;
          end
        end
      end
      CALC: begin
        step       = 1'b1;
        count_next = count_reg + 1'b1;
        if (count_reg == LAST_ITER) begin
          state_next = FIX;
        end
      end
      FIX: begin
        hi_next    = res_hi;
        lo_next    = res_lo;
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
      hi_reg    <= 32'd0;
      lo_reg    <= 32'd0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      done_reg  <= done_next;
    end
  end

  // Sign outcome and the raw dividend are captured at accept for the FIX step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg       <= 32'd0;
      is_div_reg  <= 1'b0;
      neg_reg     <= 1'b0;
      rem_neg_reg <= 1'b0;
      b_zero_reg  <= 1'b0;
    end else if (load) begin
      a_reg       <= bus.A;
      is_div_reg  <= op_is_div;
      neg_reg     <= signed_op && (bus.A[31] ^ bus.B[31]);
      rem_neg_reg <= signed_op && bus.A[31];
      b_zero_reg  <= op_is_div && (bus.B == 32'd0);
    end
  end

  always_comb begin
    bus.rd_data = 32'd0;
    if (issue && (bus.funct == FN_MFHI)) begin
      bus.rd_data = hi_reg;
    end else if (issue && (bus.funct == FN_MFLO)) begin
      bus.rd_data = lo_reg;
    end
  end

  assign bus.stall = bus.op_valid && !idle;
  assign bus.busy  = !idle;
  assign bus.done  = done_reg;
  assign bus.hi    = hi_reg;
  assign bus.lo    = lo_reg;

endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// Directed bench for hilo_muldiv_seq: a table of mult/div vectors with
// hand-computed HI/LO, plus sequences for stall, done-cycle issue and reset abort.
module tb_hilo_muldiv_seq;
  import hilo_muldiv_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;

  hilo_muldiv_seq_if bus ();

  hilo_muldiv_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_muldiv(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                            output int lat, output int busy_cnt);
    bus.op_valid = 1'b1;
    bus.funct    = f;
    bus.A        = a;
    bus.B        = b;
    tick();
    bus.op_valid = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy) busy_cnt++;
      tick();
      lat++;
      if (bus.done) break;
    end
  endtask

  initial begin
    int lat;
    int bcnt;
    int got;
    int done_seen;
    int busy_seen;

    vecs[0]  = '{FN_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[1]  = '{FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{FN_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{FN_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[4]  = '{FN_DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
    vecs[5]  = '{FN_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
    vecs[6]  = '{FN_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[7]  = '{FN_DIV,   32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    vecs[8]  = '{FN_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[9]  = '{FN_DIVU,  32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999};
    vecs[10] = '{FN_DIV,   32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF};
    vecs[11] = '{FN_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[12] = '{FN_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[13] = '{FN_DIV,   32'h80000000, 32'h00000002, 32'h00000000, 32'hC0000000};
    vecs[14] = '{FN_MULTU, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
    vecs[15] = '{FN_DIVU,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};

    rst          = 1'b1;
    bus.op_valid = 1'b0;
    bus.funct    = 6'd0;
    bus.A        = 32'd0;
    bus.B        = 32'd0;

    // Reset state, with an op presented so stall/rd_data are exercised too.
    #12;
    bus.op_valid = 1'b1;
    bus.funct    = FN_MFHI;
    #1;
    chk("rst_hi",    bus.hi,    32'd0);
    chk("rst_lo",    bus.lo,    32'd0);
    chk("rst_busy",  {31'd0, bus.busy},  32'd0);
    chk("rst_done",  {31'd0, bus.done},  32'd0);
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // First op right after release is taken at the next edge.
    bus.funct = FN_MTHI;
    bus.A     = 32'h00000011;
    tick();
    bus.op_valid = 1'b0;
    chk("first_mthi_hi", bus.hi, 32'h00000011);
    chk("first_mthi_lo", bus.lo, 32'd0);
    $display("txn mthi A=%h -> hi=%h lo=%h", 32'h11, bus.hi, bus.lo);

    for (int i = 0; i < NVEC; i++) begin
      run_muldiv(vecs[i].funct, vecs[i].a, vecs[i].b, lat, bcnt);
      chk($sformatf("v%0d_hi", i),   bus.hi, vecs[i].exp_hi);
      chk($sformatf("v%0d_lo", i),   bus.lo, vecs[i].exp_lo);
      chk($sformatf("v%0d_lat", i),  lat,    33);
      chk($sformatf("v%0d_busy", i), bcnt,   33);
      $display("txn funct=%b A=%h B=%h -> hi=%h lo=%h lat=%0d busy=%0d",
               vecs[i].funct, vecs[i].a, vecs[i].b, bus.hi, bus.lo, lat, bcnt);
    end

    // Unrecognised funct: no stall, no read data, no write.
    bus.op_valid = 1'b1;
    bus.funct    = 6'b100000;
    bus.A        = 32'hFFFF0000;
    #1;
    chk("bad_fn_stall", {31'd0, bus.stall}, 32'd0);
    chk("bad_fn_rd",    bus.rd_data, 32'd0);
    tick();
    chk("bad_fn_hi", bus.hi, 32'h80000000);
    chk("bad_fn_lo", bus.lo, 32'h00000000);
    $display("txn funct=100000 -> hi=%h lo=%h", bus.hi, bus.lo);

    // mtlo leaves HI alone; mflo reads back combinationally.
    bus.funct = FN_MTLO;
    bus.A     = 32'h0BADF00D;
    tick();
    chk("mtlo_lo", bus.lo, 32'h0BADF00D);
    chk("mtlo_hi", bus.hi, 32'h80000000);
    bus.funct = FN_MFLO;
    #1;
    chk("mflo_rd", bus.rd_data, 32'h0BADF00D);
    $display("txn mtlo/mflo -> lo=%h rd=%h", bus.lo, bus.rd_data);

    // mthi, mult, then mfhi every cycle until the done cycle.
    bus.funct = FN_MTHI;
    bus.A     = 32'hA5A5A5A5;
    tick();
    chk("seq_mthi", bus.hi, 32'hA5A5A5A5);
    bus.funct = FN_MFHI;
    #1;
    chk("seq_mfhi_idle", bus.rd_data, 32'hA5A5A5A5);
    bus.funct = FN_MULT;
    bus.A     = 32'h00010000;
    bus.B     = 32'h00030000;
    tick();
    bus.funct = FN_MFHI;
    bus.A     = 32'h0;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        got = 1;
        break;
      end
      chk($sformatf("seq_stall_c%0d", i), {31'd0, bus.stall}, 32'd1);
      chk($sformatf("seq_rd0_c%0d", i),   bus.rd_data, 32'd0);
      tick();
    end
    chk("seq_done_seen", got, 1);
    chk("seq_done_stall", {31'd0, bus.stall}, 32'd0);
    chk("seq_done_mfhi",  bus.rd_data, 32'h00000003);
    $display("txn mult in flight, mfhi at done -> rd=%h", bus.rd_data);
    // An op issued in the done cycle is accepted.
    bus.funct = FN_MTLO;
    bus.A     = 32'h00000055;
    tick();
    bus.op_valid = 1'b0;
    chk("done_cyc_mtlo_lo", bus.lo, 32'h00000055);
    chk("done_cyc_mtlo_hi", bus.hi, 32'h00000003);

    // Ops presented while busy are ignored.
    bus.op_valid = 1'b1;
    bus.funct    = FN_DIVU;
    bus.A        = 32'h00000064;
    bus.B        = 32'h00000007;
    tick();
    bus.funct = FN_MTLO;
    bus.A     = 32'hDEADBEEF;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 10) bus.funct = FN_MULT;
      tick();
      if (bus.done) begin
        got = 1;
        break;
      end
    end
    bus.op_valid = 1'b0;
    chk("stalled_done_seen", got, 1);
    chk("stalled_lo", bus.lo, 32'h0000000E);
    chk("stalled_hi", bus.hi, 32'h00000002);
    tick();
    chk("stalled_no_restart", {31'd0, bus.busy}, 32'd0);
    $display("txn divu with stalled ops -> hi=%h lo=%h", bus.hi, bus.lo);

    // Reset in the middle of a div aborts it.
    bus.op_valid = 1'b1;
    bus.funct    = FN_DIV;
    bus.A        = 32'h000003E8;
    bus.B        = 32'h00000003;
    tick();
    bus.op_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_hi",   bus.hi, 32'd0);
    chk("abort_lo",   bus.lo, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    done_seen = 0;
    busy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done) done_seen++;
      if (bus.busy) busy_seen++;
    end
    chk("abort_no_done", done_seen, 0);
    chk("abort_no_busy", busy_seen, 0);
    bus.op_valid = 1'b1;
    bus.funct    = FN_MTLO;
    bus.A        = 32'h00000001;
    tick();
    bus.op_valid = 1'b0;
    chk("abort_mtlo_lo", bus.lo, 32'h00000001);
    chk("abort_mtlo_hi", bus.hi, 32'd0);
    $display("txn div aborted by rst, then mtlo -> hi=%h lo=%h", bus.hi, bus.lo);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
